// File: rtl/framebuf_dma_arbiter.sv
// rtl/framebuf_dma_arbiter.sv - two-port burst arbiter sharing one DMA read port
// Optional aging priority for port 1 is enabled by defining FRAMEBUF_ARB_AGING_EN.
module framebuf_dma_arbiter #(
  parameter int unsigned aging_limit = 4
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [11:0] i_req0_bytes,
  input  logic [23:0] i_req0_addr,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [11:0] i_req1_bytes,
  input  logic [23:0] i_req1_addr,
  output logic        o_resp0_valid,
  output logic        o_resp0_last,
  output logic [23:0] o_resp0_addr,
  output logic [63:0] o_resp0_data,
  input  logic        i_resp0_ready,
  output logic        o_resp1_valid,
  output logic        o_resp1_last,
  output logic [23:0] o_resp1_addr,
  output logic [63:0] o_resp1_data,
  input  logic        i_resp1_ready,
  input  logic        i_req_mem_ready,
  output logic        o_req_mem_valid,
  output logic [11:0] o_req_mem_bytes,
  output logic [23:0] o_req_mem_addr,
  input  logic        i_resp_mem_valid,
  input  logic        i_resp_mem_last,
  input  logic [23:0] i_resp_mem_addr,
  input  logic [63:0] i_resp_mem_data,
  output logic        o_resp_mem_ready,
  output logic        o_owner,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_RESPONSE
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [11:0] bytes_q, bytes_d;
  logic [23:0] addr_q, addr_d;
  logic        grant;
  logic        winner;

`ifdef FRAMEBUF_ARB_AGING_EN
  localparam logic [3:0] AGE_LIMIT = 4'(aging_limit);
  logic [3:0] age_q, age_d;

  always_comb begin
    grant  = i_req0_valid | i_req1_valid;
    winner = ~i_req0_valid | (i_req1_valid & (age_q >= AGE_LIMIT));
  end

  // Counts port-0 wins while port 1 is left waiting; saturates at 15.
  always_comb begin
    age_d = age_q;
    if (state_q == ST_IDLE) begin
      if (!i_req1_valid || (grant && winner)) begin
        age_d = 4'd0;
      end else if (grant && age_q != 4'hF) begin
        age_d = age_q + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      age_q <= 4'd0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  always_comb begin
    grant  = i_req0_valid | i_req1_valid;
    winner = ~i_req0_valid;
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    bytes_d = bytes_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d = winner;
          bytes_d = winner ? i_req1_bytes : i_req0_bytes;
          addr_d  = winner ? i_req1_addr  : i_req0_addr;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (i_req_mem_ready) begin
          state_d = ST_RESPONSE;
        end
      end
      ST_RESPONSE: begin
        if (i_resp_mem_valid && o_resp_mem_ready && i_resp_mem_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      bytes_q <= 12'd0;
      addr_q  <= 24'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      bytes_q <= bytes_d;
      addr_q  <= addr_d;
    end
  end

  // Readies are gated by reset so nothing is accepted while reset is held.
  always_comb begin
    o_req0_ready     = 1'b0;
    o_req1_ready     = 1'b0;
    o_req_mem_valid  = 1'b0;
    o_resp_mem_ready = 1'b0;
    o_resp0_valid    = 1'b0;
    o_resp0_last     = 1'b0;
    o_resp0_addr     = 24'd0;
    o_resp0_data     = 64'd0;
    o_resp1_valid    = 1'b0;
    o_resp1_last     = 1'b0;
    o_resp1_addr     = 24'd0;
    o_resp1_data     = 64'd0;
    case (state_q)
      ST_IDLE: begin
        o_req0_ready = i_nrst & grant & ~winner;
        o_req1_ready = i_nrst & grant & winner;
      end
      ST_REQUEST: begin
        o_req_mem_valid = 1'b1;
      end
      ST_RESPONSE: begin
        if (owner_q) begin
          o_resp_mem_ready = i_resp1_ready;
          o_resp1_valid    = i_resp_mem_valid;
          o_resp1_last     = i_resp_mem_last;
          o_resp1_addr     = i_resp_mem_addr;
          o_resp1_data     = i_resp_mem_data;
        end else begin
          o_resp_mem_ready = i_resp0_ready;
          o_resp0_valid    = i_resp_mem_valid;
          o_resp0_last     = i_resp_mem_last;
          o_resp0_addr     = i_resp_mem_addr;
          o_resp0_data     = i_resp_mem_data;
        end
      end
      default: ;
    endcase
  end

  assign o_req_mem_bytes = bytes_q;
  assign o_req_mem_addr  = addr_q;
  assign o_owner         = owner_q;
  assign o_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_framebuf_dma_arbiter.sv
// tb/tb_framebuf_dma_arbiter.sv - randomized self-checking bench for framebuf_dma_arbiter
module tb_framebuf_dma_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [11:0] req0_bytes, req1_bytes, mem_bytes;
  logic [23:0] req0_addr, req1_addr, mem_addr;
  logic        resp0_valid, resp0_last, resp0_ready;
  logic        resp1_valid, resp1_last, resp1_ready;
  logic [23:0] resp0_addr, resp1_addr;
  logic [63:0] resp0_data, resp1_data;
  logic        req_mem_ready, req_mem_valid;
  logic        rmem_valid, rmem_last, rmem_ready;
  logic [23:0] rmem_addr;
  logic [63:0] rmem_data;
  logic        owner, busy;

  int errors = 0;
  int checks = 0;
  int age_m  = 0;

  framebuf_dma_arbiter #(.aging_limit(LIMIT)) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_bytes(req0_bytes), .i_req0_addr(req0_addr),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_bytes(req1_bytes), .i_req1_addr(req1_addr),
    .o_resp0_valid(resp0_valid), .o_resp0_last(resp0_last),
    .o_resp0_addr(resp0_addr), .o_resp0_data(resp0_data), .i_resp0_ready(resp0_ready),
    .o_resp1_valid(resp1_valid), .o_resp1_last(resp1_last),
    .o_resp1_addr(resp1_addr), .o_resp1_data(resp1_data), .i_resp1_ready(resp1_ready),
    .i_req_mem_ready(req_mem_ready), .o_req_mem_valid(req_mem_valid),
    .o_req_mem_bytes(mem_bytes), .o_req_mem_addr(mem_addr),
    .i_resp_mem_valid(rmem_valid), .i_resp_mem_last(rmem_last),
    .i_resp_mem_addr(rmem_addr), .i_resp_mem_data(rmem_data),
    .o_resp_mem_ready(rmem_ready), .o_owner(owner), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: port 0 first, unless port 1 has waited aging_limit grants.
  function automatic bit model_winner(input bit v0, input bit v1);
`ifdef FRAMEBUF_ARB_AGING_EN
    if (v0 && v1) return (age_m >= LIMIT);
`endif
    return !v0;
  endfunction

  task automatic model_grant(input bit w, input bit v1);
    if (w || !v1) age_m = 0;
    else if (age_m < 15) age_m = age_m + 1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_bytes = 0; req1_bytes = 0; req0_addr = 0; req1_addr = 0;
    resp0_ready = 0; resp1_ready = 0; req_mem_ready = 0;
    rmem_valid = 0; rmem_last = 0; rmem_addr = 0; rmem_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_memv"}, req_mem_valid, 0);
    check({tag, "_bytes"}, mem_bytes, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_rdy"}, {req0_ready, req1_ready, rmem_ready}, 0);
    check({tag, "_rv"}, {resp0_valid, resp1_valid}, 0);
  endtask

  // rmode: 0 random valid/ready, 1 always ready, 2 owner ready toggles each cycle
  task automatic run_burst(input bit v0, input bit v1,
                           input logic [11:0] b0, input logic [11:0] b1,
                           input logic [23:0] a0, input logic [23:0] a1,
                           input int gap, input int stall, input int rmode,
                           input int abort_at, output bit w);
    logic [11:0] eb;
    logic [23:0] ea;
    logic [63:0] d;
    bit          mv, rdy, done;
    int          n, k, cyc;
    for (int g = 0; g < gap; g++) begin
      clear_inputs();
      rmem_valid = 1; rmem_last = 1; rmem_data = {$urandom(), $urandom()};
      #1;
      check("idle_req_rdy", {req0_ready, req1_ready}, 0);
      check("stray_mem_rdy", rmem_ready, 0);
      check("stray_resp_v", {resp0_valid, resp1_valid}, 0);
      check("idle_busy", busy, 0);
      age_m = 0;
      step();
    end
    clear_inputs();
    req0_valid = v0; req1_valid = v1;
    req0_bytes = b0; req1_bytes = b1; req0_addr = a0; req1_addr = a1;
    w = model_winner(v0, v1);
    #1;
    check("grant_rdy0", req0_ready, !w);
    check("grant_rdy1", req1_ready, w);
    model_grant(w, v1);
    step();
    eb = w ? b1 : b0;
    ea = w ? a1 : a0;
    if (w) req1_valid = 0; else req0_valid = 0;
    req0_addr = $urandom(); req1_addr = $urandom();
    req0_bytes = $urandom(); req1_bytes = $urandom();
    check("owner", owner, w);
    for (int s = 0; s <= stall; s++) begin
      req_mem_ready = (s == stall);
      #1;
      check("memv", req_mem_valid, 1);
      check("mem_bytes", mem_bytes, eb);
      check("mem_addr", mem_addr, ea);
      check("req_rdy_hold", {req0_ready, req1_ready, rmem_ready}, 0);
      step();
    end
    req_mem_ready = 0;
    n = int'(eb) / 8;
    k = 0; cyc = 0; done = 0;
    while (!done && cyc < 400) begin
      mv  = (rmode == 0) ? ($urandom_range(3) != 0) : 1'b1;
      rdy = (rmode == 0) ? 1'($urandom_range(1)) : (rmode == 1) ? 1'b1 : (cyc % 2 == 0);
      d   = {$urandom(), $urandom()};
      rmem_valid = mv; rmem_last = (k == n - 1); rmem_data = d;
      rmem_addr  = ea + 24'(8 * k);
      if (w) begin resp1_ready = rdy; resp0_ready = 1'($urandom_range(1)); end
      else   begin resp0_ready = rdy; resp1_ready = 1'($urandom_range(1)); end
      #1;
      check("mem_rdy", rmem_ready, rdy);
      check("owner_v", w ? resp1_valid : resp0_valid, mv);
      check("other_v", w ? {resp0_valid, resp0_last} : {resp1_valid, resp1_last}, 0);
      check("other_d", w ? resp0_data : resp1_data, 0);
      if (mv) begin
        check("beat_data", w ? resp1_data : resp0_data, d);
        check("beat_addr", w ? resp1_addr : resp0_addr, ea + 24'(8 * k));
        check("beat_last", w ? resp1_last : resp0_last, (k == n - 1));
      end
      if (abort_at == k && mv) begin
        #1 nrst = 0;
        #1;
        check_reset_outputs("midrst");
        step();
        clear_inputs();
        nrst = 1;
        age_m = 0;
        return;
      end
      if (mv && rdy) begin
        k++;
        if (k == n) done = 1;
      end
      step();
      cyc++;
    end
    check("beats_done", done, 1);
    clear_inputs();
    #1;
    check("idle_after_last", busy, 0);
  endtask

  initial begin
    bit         w;
    bit [5:0]   order;
    bit [5:0]   exp_order;
    bit         v0, v1;
    clear_inputs();
    nrst = 0;
    req0_valid = 1; req1_valid = 1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    nrst = 1;
    clear_inputs();
    step();

    run_burst(1, 0, 12'd64, 12'd0, 24'h000800, 24'h0, 1, 0, 1, -1, w);
    check("t1_winner", w, 0);

    for (int i = 0; i < 6; i++) begin
      run_burst(1, 1, 12'd16, 12'd24, 24'h001000 + 24'(i * 64), 24'h200000, 0, 0, 1, -1, w);
      order[i] = w;
    end
`ifdef FRAMEBUF_ARB_AGING_EN
    exp_order = 6'b010000;
`else
    exp_order = 6'b000000;
`endif
    check("grant_order", order, exp_order);

    run_burst(1, 0, 12'd64, 12'd0, 24'h004000, 24'h0, 0, 0, 2, -1, w);
    run_burst(0, 1, 12'd0, 12'd32, 24'h0, 24'h123400, 0, 10, 1, -1, w);
    check("t4_winner", w, 1);
    run_burst(0, 1, 12'd0, 12'd8, 24'h0, 24'h00aa00, 3, 0, 1, -1, w);

    run_burst(1, 0, 12'd64, 12'd0, 24'h005000, 24'h0, 0, 0, 1, 2, w);
    #1;
    check_reset_outputs("post_rst");
    run_burst(0, 1, 12'd0, 12'd32, 24'h0, 24'h00c000, 0, 1, 1, -1, w);
    check("post_rst_winner", w, 1);

    for (int i = 0; i < 25; i++) begin
      v0 = 1'($urandom_range(1));
      v1 = v0 ? 1'($urandom_range(1)) : 1'b1;
      run_burst(v0, v1, 12'(8 * $urandom_range(1, 8)), 12'(8 * $urandom_range(1, 8)),
                24'($urandom()), 24'($urandom()), $urandom_range(2), $urandom_range(3), 0, -1, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
